scsi_inq_capture: RTL and testbench

- Downstream consumer of the SCSI inquiry match stage.
- Takes the two-channel inquiry pass-through stream plus the per-channel match flag, and captures the payload of matched inquiry-response frames into a committed frame buffer.
- Each frame is prefixed by a header word; software drains the buffer through a registered pop interface (misc FIFO read side).
- Errored frames are rolled back; frames that cannot fit are dropped and counted.

---
 rtl/scsi_inq_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_scsi_inq_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_inq_capture.sv
// scsi_inq_capture: captures matched inquiry-response frames from the two-channel
// match stage into a committed frame buffer, which is drained through a registered pop port.
// Each frame is stored as a header word followed by up to MAX_WORDS payload words.
// Header: [63] channel, [62] truncated, [61:56] stored word count, [55:0] timestamp.
// Optional: define SCSI_INQ_CAPTURE_TS_EN to carry the first-word timestamp in the header.
// Without it, header bits [55:0] are zero and no timestamp register is built.
module scsi_inq_capture #(
    parameter int DEPTH     = 256,
    parameter int MAX_WORDS = 32,
    parameter int CNT_W     = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [1:0][63:0]      iINQ_DATA,
    input  logic [1:0]            iINQ_DATA_VALID,
    input  logic [1:0]            iINQ_EOP,
    input  logic [1:0]            iINQ_IS_MATCH,
    input  logic [1:0]            iINQ_ERR,
    input  logic [1:0][55:0]      iINQ_LAST_TS,
    input  logic                  iRD_EN,
    output logic [63:0]           oRD_DATA,
    output logic                  oRD_VALID,
    output logic                  oRD_EMPTY,
    output logic [CNT_W-1:0]      oFRAME_CNT,
    output logic [CNT_W-1:0]      oERR_CNT,
    output logic [CNT_W-1:0]      oOVFL_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CAP    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_SKIP   = 2'd3;

    logic [1:0]       state, stateN;
    logic             chan, chanN;
    logic [PW-1:0]    wrPtr, wrPtrN, cmPtr, cmPtrN, rdPtr, usedP;
    logic [AW-1:0]    hdrAddr, hdrAddrN;
    logic [5:0]       count, countN;
    logic             trunc, truncN;
    logic [63:0]      mem [DEPTH];

    logic [1:0]       start;
    logic             sel, cVld, cEop, cErr, spaceOk, pop;
    logic [63:0]      cData;
    logic [55:0]      tsVal;
    logic             tsLoad;
    logic             memWe;
    logic [AW-1:0]    memAddr;
    logic [63:0]      memWdata;
    logic             frameInc, errInc;
    logic [1:0]       ovflInc;

    // Saturating add for the statistics counters (up to two drops per cycle).
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] v, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign start = iINQ_IS_MATCH & iINQ_DATA_VALID;
    // IDLE/COMMIT look at the starting channel (ch0 has priority); CAP/SKIP at the locked one.
    assign sel   = (state == S_IDLE || state == S_COMMIT) ? ~start[0] : chan;
    assign cVld  = iINQ_DATA_VALID[sel];
    assign cEop  = iINQ_EOP[sel] & cVld;
    assign cErr  = iINQ_ERR[sel] & cVld;
    assign cData = iINQ_DATA[sel];

    // Room for a header plus a full-length payload is required before accepting a frame.
    assign usedP   = wrPtr - rdPtr;
    assign spaceOk = 32'(usedP) <= 32'(DEPTH - MAX_WORDS - 1);

    assign oRD_EMPTY = (rdPtr == cmPtr);
    assign pop       = iRD_EN & ~oRD_EMPTY;

`ifdef SCSI_INQ_CAPTURE_TS_EN
    logic [55:0] tsReg;
    // Timestamp of the frame's first word, reported in its header.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)     tsReg <= '0;
        else if (tsLoad) tsReg <= iINQ_LAST_TS[sel];
    end
    assign tsVal = tsReg;
`else
    logic unusedTs;
    assign unusedTs = ^{iINQ_LAST_TS, tsLoad};
    assign tsVal    = '0;
`endif

    // Capture FSM: next state, buffer write and counter increments.
    always_comb begin
        stateN   = state;
        chanN    = chan;
        wrPtrN   = wrPtr;
        cmPtrN   = cmPtr;
        hdrAddrN = hdrAddr;
        countN   = count;
        truncN   = trunc;
        tsLoad   = 1'b0;
        memWe    = 1'b0;
        memAddr  = wrPtr[AW-1:0];
        memWdata = cData;
        frameInc = 1'b0;
        errInc   = 1'b0;
        ovflInc  = 2'd0;
        case (state)
            S_IDLE: begin
                if (|start) begin
                    if (&start) ovflInc = 2'd1;
                    if (!spaceOk) begin
                        ovflInc = ovflInc + 2'd1;
                        if (!(cEop | cErr)) begin
                            stateN = S_SKIP;
                            chanN  = sel;
                        end
                    end else begin
                        // Reserve the header slot, payload starts right after it.
                        chanN    = sel;
                        hdrAddrN = wrPtr[AW-1:0];
                        tsLoad   = 1'b1;
                        memWe    = 1'b1;
                        memAddr  = wrPtr[AW-1:0] + AW'(1);
                        wrPtrN   = wrPtr + PW'(2);
                        countN   = 6'd1;
                        truncN   = 1'b0;
                        stateN   = S_CAP;
                        if (cErr) begin
                            wrPtrN = cmPtr;
                            errInc = 1'b1;
                            stateN = S_IDLE;
                        end else if (cEop) begin
                            stateN = S_COMMIT;
                        end
                    end
                end
            end
            S_CAP: begin
                if (start[~chan]) ovflInc = 2'd1;
                if (cVld) begin
                    if (count < 6'(MAX_WORDS)) begin
                        memWe  = 1'b1;
                        wrPtrN = wrPtr + PW'(1);
                        countN = count + 6'd1;
                    end else begin
                        truncN = 1'b1;
                    end
                    if (cErr) begin
                        wrPtrN = cmPtr;
                        errInc = 1'b1;
                        stateN = S_IDLE;
                    end else if (cEop) begin
                        stateN = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                memWe    = 1'b1;
                memAddr  = hdrAddr;
                memWdata = {chan, trunc, count, tsVal};
                cmPtrN   = wrPtr;
                frameInc = 1'b1;
                stateN   = S_IDLE;
                // No capture slot this cycle: every start is dropped.
                ovflInc  = {1'b0, start[0]} + {1'b0, start[1]};
                if ((|start) && !(cEop | cErr)) begin
                    stateN = S_SKIP;
                    chanN  = sel;
                end
            end
            default: begin
                if (start[~chan]) ovflInc = 2'd1;
                if (cEop | cErr) stateN = S_IDLE;
            end
        endcase
    end

    // FSM, write-side pointers and statistics registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            chan       <= 1'b0;
            wrPtr      <= '0;
            cmPtr      <= '0;
            hdrAddr    <= '0;
            count      <= '0;
            trunc      <= 1'b0;
            oFRAME_CNT <= '0;
            oERR_CNT   <= '0;
            oOVFL_CNT  <= '0;
        end else begin
            state      <= stateN;
            chan       <= chanN;
            wrPtr      <= wrPtrN;
            cmPtr      <= cmPtrN;
            hdrAddr    <= hdrAddrN;
            count      <= countN;
            trunc      <= truncN;
            oFRAME_CNT <= satAdd(oFRAME_CNT, {1'b0, frameInc});
            oERR_CNT   <= satAdd(oERR_CNT, {1'b0, errInc});
            oOVFL_CNT  <= satAdd(oOVFL_CNT, ovflInc);
        end
    end

    // Buffer storage; contents are not reset, only the pointers are.
    always_ff @(posedge iCLK) begin
        if (memWe) mem[memAddr] <= memWdata;
    end

    // Registered pop port over committed words only.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rdPtr     <= '0;
            oRD_DATA  <= '0;
            oRD_VALID <= 1'b0;
        end else begin
            oRD_VALID <= pop;
            if (pop) begin
                oRD_DATA <= mem[rdPtr[AW-1:0]];
                rdPtr    <= rdPtr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_scsi_inq_capture.sv
// Scenario bench for scsi_inq_capture (DEPTH=128, MAX_WORDS=32).
// Expected buffer words are queued as frames are driven and compared as they are popped.
module tb_scsi_inq_capture;

    localparam int DEPTH = 128;
    localparam int MW    = 32;
`ifdef SCSI_INQ_CAPTURE_TS_EN
    localparam logic TS_EN = 1'b1;
`else
    localparam logic TS_EN = 1'b0;
`endif

    logic             iCLK, iRST_N;
    logic [1:0][63:0] iINQ_DATA;
    logic [1:0]       iINQ_DATA_VALID, iINQ_EOP, iINQ_IS_MATCH, iINQ_ERR;
    logic [1:0][55:0] iINQ_LAST_TS;
    logic             iRD_EN;
    logic [63:0]      oRD_DATA;
    logic             oRD_VALID, oRD_EMPTY;
    logic [15:0]      oFRAME_CNT, oERR_CNT, oOVFL_CNT;

    logic [63:0] expQ[$];
    logic [63:0] gotD[$];
    logic        gotV[$];
    int vectors = 0;
    int miscompares = 0;

    scsi_inq_capture #(.DEPTH(DEPTH), .MAX_WORDS(MW), .CNT_W(16)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iINQ_DATA(iINQ_DATA), .iINQ_DATA_VALID(iINQ_DATA_VALID), .iINQ_EOP(iINQ_EOP),
        .iINQ_IS_MATCH(iINQ_IS_MATCH), .iINQ_ERR(iINQ_ERR), .iINQ_LAST_TS(iINQ_LAST_TS),
        .iRD_EN(iRD_EN), .oRD_DATA(oRD_DATA), .oRD_VALID(oRD_VALID), .oRD_EMPTY(oRD_EMPTY),
        .oFRAME_CNT(oFRAME_CNT), .oERR_CNT(oERR_CNT), .oOVFL_CNT(oOVFL_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clrIn();
        iINQ_DATA       = '0;
        iINQ_DATA_VALID = '0;
        iINQ_EOP        = '0;
        iINQ_IS_MATCH   = '0;
        iINQ_ERR        = '0;
        iINQ_LAST_TS    = '0;
    endtask

    task automatic doReset();
        clrIn();
        iRD_EN = 1'b0;
        iRST_N = 1'b0;
        tick();
        tick();
        iRST_N = 1'b1;
        tick();
        expQ.delete();
    endtask

    function automatic logic [63:0] hdr(input int ch, input int n, input logic [55:0] ts);
        logic [5:0] c;
        c = (n > MW) ? 6'(MW) : 6'(n);
        return {ch[0], (n > MW), c, ts & {56{TS_EN}}};
    endfunction

    task automatic setWord(input int ch, input logic [63:0] d, input logic m, input logic e,
                           input logic er, input logic [55:0] ts);
        iINQ_DATA_VALID[ch] = 1'b1;
        iINQ_DATA[ch]       = d;
        iINQ_IS_MATCH[ch]   = m;
        iINQ_EOP[ch]        = e;
        iINQ_ERR[ch]        = er;
        iINQ_LAST_TS[ch]    = ts;
    endtask

    // Drives one frame; queues its expected header and payload if it should be committed.
    task automatic sendFrame(input int ch, input int n, input logic [63:0] base,
                             input logic [55:0] ts, input int errAt, input bit cap);
        if (cap && errAt < 0) begin
            expQ.push_back(hdr(ch, n, ts));
            for (int i = 0; i < n && i < MW; i++) expQ.push_back(base + 64'(i));
        end
        for (int i = 0; i < n; i++) begin
            clrIn();
            setWord(ch, base + 64'(i), i == 0, i == n - 1, i == errAt, ts);
            tick();
            if (i == errAt) break;
        end
        clrIn();
    endtask

    // Pops n words back to back and records what came out.
    task automatic popWords(input int n);
        gotD.delete();
        gotV.delete();
        iRD_EN = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            gotD.push_back(oRD_DATA);
            gotV.push_back(oRD_VALID);
        end
        iRD_EN = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        doReset();
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b want 1", oRD_EMPTY); end
        vectors++; if (oRD_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", oRD_VALID); end
        vectors++; if (oRD_DATA !== 64'd0) begin miscompares++; $display("FAIL rst_data got %h want 0", oRD_DATA); end
        vectors++; if (oFRAME_CNT !== 16'd0 || oERR_CNT !== 16'd0 || oOVFL_CNT !== 16'd0) begin
            miscompares++; $display("FAIL rst_cnt got %0d/%0d/%0d want 0/0/0", oFRAME_CNT, oERR_CNT, oOVFL_CNT); end
        // Partial frame cut by reset is discarded; next frame is clean.
        clrIn(); setWord(0, 64'hDEAD_0000, 1'b1, 1'b0, 1'b0, 56'h77); tick();
        clrIn(); setWord(0, 64'hDEAD_0001, 1'b0, 1'b0, 1'b0, 56'h77); tick();
        doReset();
        clrIn(); setWord(0, 64'hDEAD_0002, 1'b0, 1'b1, 1'b0, 56'h77); tick(); clrIn();
        sendFrame(1, 2, 64'hAAAA_0000, 56'hABCDEF, -1, 1'b1);
        tick(); tick();
        popWords(3);
        for (int i = 0; i < 3; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL rst_frame w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        vectors++; if (oFRAME_CNT !== 16'd1) begin miscompares++; $display("FAIL rst_fcnt got %0d want 1", oFRAME_CNT); end
    endtask

    task automatic test_basic();
        logic [63:0] e;
        doReset();
        sendFrame(0, 4, 64'hD000_0000_0000_0000, 56'h123456, -1, 1'b1);
        tick(); tick();
        popWords(5);
        for (int i = 0; i < 5; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL basic w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        vectors++; if (oFRAME_CNT !== 16'd1) begin miscompares++; $display("FAIL basic_fcnt got %0d want 1", oFRAME_CNT); end
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL basic_empty got %b want 1", oRD_EMPTY); end
    endtask

    task automatic test_trunc();
        logic [63:0] e;
        doReset();
        sendFrame(1, 40, 64'h1100_0000_0000_0000, 56'h55AA, -1, 1'b1);
        tick(); tick();
        popWords(33);
        for (int i = 0; i < 33; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL trunc w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        vectors++; if (oFRAME_CNT !== 16'd1) begin miscompares++; $display("FAIL trunc_fcnt got %0d want 1", oFRAME_CNT); end
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL trunc_empty got %b want 1", oRD_EMPTY); end
    endtask

    task automatic test_error();
        logic [63:0] e;
        doReset();
        sendFrame(0, 5, 64'hEEEE_0000, 56'h1, 2, 1'b0);
        tick(); tick();
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL err_empty got %b want 1", oRD_EMPTY); end
        vectors++; if (oERR_CNT !== 16'd1) begin miscompares++; $display("FAIL err_cnt got %0d want 1", oERR_CNT); end
        vectors++; if (oFRAME_CNT !== 16'd0) begin miscompares++; $display("FAIL err_fcnt got %0d want 0", oFRAME_CNT); end
        sendFrame(0, 3, 64'h6060_0000, 56'h2, -1, 1'b1);
        tick(); tick();
        popWords(4);
        for (int i = 0; i < 4; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL err_next w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL err_next_empty got %b want 1", oRD_EMPTY); end
    endtask

    task automatic test_simul();
        logic [63:0] e;
        doReset();
        expQ.push_back(hdr(0, 4, 56'h9));
        for (int k = 0; k < 4; k++) expQ.push_back(64'hA0 + 64'(k));
        for (int k = 0; k < 7; k++) begin
            clrIn();
            if (k < 4) setWord(0, 64'hA0 + 64'(k), k == 0, k == 3, 1'b0, 56'h9);
            if (k < 4) setWord(1, 64'hB0 + 64'(k), k == 0, k == 3, 1'b0, 56'h8);
            else       setWord(1, 64'hC0 + 64'(k), k == 4, k == 6, 1'b0, 56'h7);
            tick();
            if (k == 0) begin
                vectors++; if (oOVFL_CNT !== 16'd1) begin miscompares++; $display("FAIL simul_ovfl1 got %0d want 1", oOVFL_CNT); end
            end
        end
        clrIn(); tick(); tick();
        vectors++; if (oOVFL_CNT !== 16'd2) begin miscompares++; $display("FAIL simul_ovfl2 got %0d want 2", oOVFL_CNT); end
        vectors++; if (oFRAME_CNT !== 16'd1) begin miscompares++; $display("FAIL simul_fcnt got %0d want 1", oFRAME_CNT); end
        popWords(5);
        for (int i = 0; i < 5; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL simul w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL simul_empty got %b want 1", oRD_EMPTY); end
    endtask

    task automatic test_fill_wrap();
        logic [63:0] e;
        doReset();
        for (int f = 0; f < 3; f++) begin
            sendFrame(f % 2, 32, 64'hF000_0000 + 64'(f) * 64'h100, 56'(f + 16), -1, 1'b1);
            clrIn(); tick();
        end
        sendFrame(0, 32, 64'hBAD0_0000, 56'h3, -1, 1'b0);
        tick(); tick();
        vectors++; if (oFRAME_CNT !== 16'd3) begin miscompares++; $display("FAIL fill_fcnt got %0d want 3", oFRAME_CNT); end
        vectors++; if (oOVFL_CNT !== 16'd1) begin miscompares++; $display("FAIL fill_ovfl got %0d want 1", oOVFL_CNT); end
        popWords(33);
        for (int i = 0; i < 33; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL fill_f0 w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        sendFrame(1, 32, 64'hF0F0_0000, 56'h4242, -1, 1'b1);
        tick(); tick();
        popWords(99);
        for (int i = 0; i < 99; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL fill_wrap w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        vectors++; if (oFRAME_CNT !== 16'd4) begin miscompares++; $display("FAIL wrap_fcnt got %0d want 4", oFRAME_CNT); end
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL wrap_empty got %b want 1", oRD_EMPTY); end
    endtask

    task automatic test_single();
        logic [63:0] e;
        doReset();
        sendFrame(1, 1, 64'h5151_5151, 56'hFEDCBA, -1, 1'b1);
        tick(); tick();
        popWords(2);
        for (int i = 0; i < 2; i++) begin
            e = expQ.pop_front(); vectors++;
            if (!gotV[i] || gotD[i] !== e) begin miscompares++; $display("FAIL single w%0d got %h v%b want %h", i, gotD[i], gotV[i], e); end
        end
        popWords(2);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (gotV[i] !== 1'b0) begin miscompares++; $display("FAIL empty_pop c%0d valid got %b want 0", i, gotV[i]); end
        end
        vectors++; if (oRD_EMPTY !== 1'b1) begin miscompares++; $display("FAIL single_empty got %b want 1", oRD_EMPTY); end
    endtask

    initial begin
        clrIn();
        iRD_EN = 1'b0;
        iRST_N = 1'b1;
        test_reset();
        test_basic();
        test_trunc();
        test_error();
        test_simul();
        test_fill_wrap();
        test_single();
        vectors++;
        if (expQ.size() != 0) begin miscompares++; $display("FAIL leftover_expect got %0d want 0", expQ.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
